// File: rtl/dec_t3_pkg.sv
// Shared widths and the default minterm mask for the dec_t3 decoder.
package dec_t3_pkg;

    localparam int unsigned DEC_W = 4;
    localparam int unsigned DEC_N = 16;

    // Primes below 16: {2,3,5,7,11,13}
    localparam logic [DEC_N-1:0] PRIME_MINTERMS = 16'h28AC;

endpackage

// File: rtl/dec_4to16.sv
// Combinational 4-to-16 one-hot decoder; an unknown code drives every line low.
module dec_4to16
    import dec_t3_pkg::*;
(
    input  logic [DEC_W-1:0] in,
    output logic [DEC_N-1:0] onehot
);

    // Explicit case so an X/Z code falls through to the all-zero default.
    always_comb begin
        onehot = '0;
        case (in)
            4'd0:    onehot = 16'h0001;
            4'd1:    onehot = 16'h0002;
            4'd2:    onehot = 16'h0004;
            4'd3:    onehot = 16'h0008;
            4'd4:    onehot = 16'h0010;
            4'd5:    onehot = 16'h0020;
            4'd6:    onehot = 16'h0040;
            4'd7:    onehot = 16'h0080;
            4'd8:    onehot = 16'h0100;
            4'd9:    onehot = 16'h0200;
            4'd10:   onehot = 16'h0400;
            4'd11:   onehot = 16'h0800;
            4'd12:   onehot = 16'h1000;
            4'd13:   onehot = 16'h2000;
            4'd14:   onehot = 16'h4000;
            4'd15:   onehot = 16'h8000;
            default: onehot = '0;
        endcase
    end

endmodule

// File: rtl/dec_t3.sv
// Minterm decoder: one-hot decode of A, masked by MINTERMS, OR-reduced and registered.
module dec_t3
    import dec_t3_pkg::*;
#(
    parameter logic [DEC_N-1:0] MINTERMS = PRIME_MINTERMS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEC_W-1:0] A,
    output logic             X
);

    logic [DEC_N-1:0] onehot;
    logic             x_d;

    dec_4to16 u_dec (
        .in     (A),
        .onehot (onehot)
    );

    always_comb begin
        x_d = |(onehot & MINTERMS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            X <= 1'b0;
        end else begin
            X <= x_d;
        end
    end

endmodule

// File: tb/tb_dec_t3.sv
// Directed bench for dec_t3: default prime mask plus an instance overridden to 16'h8001.
module tb_dec_t3;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic       x_def;
    logic       x_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    dec_t3 u_dut (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .X   (x_def)
    );

    dec_t3 #(
        .MINTERMS (16'h8001)
    ) u_dut_ovr (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .X   (x_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs away from the active edge, then sample just after it.
    task automatic cycle(input logic r, input logic [3:0] av);
        @(negedge clk);
        rst = r;
        a   = av;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 4'b0011);
            n_checks++;
            if (x_def !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: X=%b expected 0", i, x_def);
            end
        end
        cycle(1'b0, 4'b0011);
        n_checks++;
        if (x_def !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: X=%b expected 1", x_def);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_tab;
        exp_tab = 16'b0010_1000_1010_1100; // bit i = expected X for A == i
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 4'(i));
            n_checks++;
            if (x_def !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL sweep A=%0d: X=%b expected %b", i, x_def, exp_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [3:0] av;
            logic       ex;
            av = (i % 2 == 0) ? 4'b0101 : 4'b0100;
            ex = (i % 2 == 0) ? 1'b1 : 1'b0;
            cycle(1'b0, av);
            n_checks++;
            if (x_def !== ex) begin
                n_fail++;
                $display("FAIL toggle[%0d] A=%b: X=%b expected %b", i, av, x_def, ex);
            end
        end
    endtask

    task automatic test_midstream_reset();
        cycle(1'b0, 4'b1101);
        n_checks++;
        if (x_def !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_before: X=%b expected 1", x_def);
        end
        cycle(1'b1, 4'b1101);
        n_checks++;
        if (x_def !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_during: X=%b expected 0", x_def);
        end
        cycle(1'b0, 4'b1101);
        n_checks++;
        if (x_def !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_after: X=%b expected 1", x_def);
        end
    endtask

    task automatic test_override();
        for (int i = 0; i < 16; i++) begin
            logic ex;
            ex = (i == 0 || i == 15) ? 1'b1 : 1'b0;
            cycle(1'b0, 4'(i));
            n_checks++;
            if (x_ovr !== ex) begin
                n_fail++;
                $display("FAIL override A=%0d: X=%b expected %b", i, x_ovr, ex);
            end
        end
    endtask

    task automatic test_unknown();
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'bxx01);
        n_checks++;
        if (x_def !== 1'b0) begin
            n_fail++;
            $display("FAIL unknown_default: X=%b expected 0", x_def);
        end
        n_checks++;
        if (x_ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL unknown_override: X=%b expected 0", x_ovr);
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'b0000;
        test_reset();
        test_sweep();
        test_back_to_back();
        test_midstream_reset();
        test_override();
        test_unknown();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
